vm2002_multi: RTL and testbench

Parametrised next-generation vending-machine core replacing the fixed 7-item controller. Holds a per-item stock/cost table loaded in supplier mode, runs the user purchase flow (select, coin collection with inactivity timeout, dispense, change/refund) and reports status to the system-level interface. Widths, item count and timeout are parameters. Sits between the button/coin front end and the product dispenser.

---
 rtl/vm2002_multi.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_vm2002_multi.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vm2002_multi.sv
// vm2002_multi: parametrised vending-machine core.
// Holds a per-item stock/cost table written in supplier mode. Runs the purchase
// flow: select, coin collection with an inactivity timeout, then dispense or refund.
// Optional feature macro: VM2002_CREDIT_CARRY_EN. When it is defined, change
// after a dispense stays in amount as credit for the next purchase instead of
// being returned in balance.
// Every output is a register. Its value is computed from the transition taken
// at the same edge, so a decision made at edge N shows on the outputs right after edge N.
module vm2002_multi #(
    parameter int  NUM_ITEMS   = 7,
    parameter int  CNT_W       = 4,
    parameter int  AMT_W       = 8,
    parameter int  TIMEOUT_CYC = 64,
    localparam int IDX_W       = $clog2(NUM_ITEMS + 1)
) (
    input  logic             clk,
    input  logic             hrst_n,
    input  logic             srst,
    input  logic             valid,
    input  logic [IDX_W-1:0] item,
    input  logic [CNT_W-1:0] count,
    input  logic [AMT_W-1:0] cost,
    input  logic [IDX_W-1:0] buttons,
    input  logic [1:0]       coins,
    input  logic             select,
    output logic [1:0]       status,
    output logic             insert_coins,
    output logic             start_timer,
    output logic             timeout,
    output logic             insufficient_amount,
    output logic [AMT_W-1:0] amount,
    output logic [AMT_W-1:0] balance,
    output logic [IDX_W-1:0] product,
    output logic             vend,
    output logic             coin_reject
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_AVAIL = 2'd1;
    localparam logic [1:0]       ST_OOS   = 2'd2;
    localparam logic [1:0]       ST_BUSY  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_COLLECT  = 3'd2,
        S_DISPENSE = 3'd3,
        S_REFUND   = 3'd4
    } state_t;

    // Coin code to value in cents. The result is one bit wider than amount,
    // so that an overflowing sum can be detected.
    function automatic logic [AMT_W:0] coin_value(input logic [1:0] c);
        logic [AMT_W:0] v;
        case (c)
            2'd1:    v = (AMT_W + 1)'(5);
            2'd2:    v = (AMT_W + 1)'(10);
            2'd3:    v = (AMT_W + 1)'(25);
            default: v = {(AMT_W + 1){1'b0}};
        endcase
        return v;
    endfunction

    // True for item indices 1..NUM_ITEMS. Index 0 means "none".
    function automatic logic idx_valid(input logic [IDX_W-1:0] idx);
        logic ok;
        ok = 1'b0;
        for (int i = 1; i <= NUM_ITEMS; i++) begin
            if (idx == IDX_W'(i)) begin
                ok = 1'b1;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [AMT_W-1:0] amount_q, amount_d;
    logic [AMT_W-1:0] balance_q, balance_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       status_q, status_d;
    logic [IDX_W-1:0] product_q, product_d;
    logic             collect_q, collect_d;
    logic             insuff_q, insuff_d;
    logic             timeout_q, timeout_d;
    logic             vend_q, vend_d;
    logic             reject_q, reject_d;

    logic [CNT_W-1:0] count_q [0:NUM_ITEMS];
    logic [AMT_W-1:0] cost_q  [0:NUM_ITEMS];

    logic             wr_en_s;
    logic             dec_en_s;
    logic             btn_ok_s;
    logic [IDX_W-1:0] btn_idx_s;
    logic [CNT_W-1:0] btn_stock_s;
    logic [CNT_W-1:0] sel_stock_s;
    logic [AMT_W-1:0] price_s;
    logic [AMT_W:0]   sum_s;
    logic             coin_ok_s;
    logic [AMT_W-1:0] credit_s;

    // Table lookups and coin arithmetic shared by the FSM.
    // credit_s is the amount after this cycle's coin, if that coin is accepted.
    always_comb begin
        btn_ok_s    = idx_valid(buttons);
        btn_idx_s   = btn_ok_s ? buttons : {IDX_W{1'b0}};
        btn_stock_s = count_q[btn_idx_s];
        sel_stock_s = count_q[sel_q];
        price_s     = cost_q[sel_q];
        sum_s       = {1'b0, amount_q} + coin_value(coins);
        coin_ok_s   = (coins != 2'd0) && !sum_s[AMT_W];
        credit_s    = coin_ok_s ? sum_s[AMT_W-1:0] : amount_q;
    end

    // Next-state and next-output logic for the purchase flow.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        amount_d  = amount_q;
        balance_d = balance_q;
        timer_d   = timer_q;
        status_d  = status_q;
        insuff_d  = insuff_q;
        product_d = {IDX_W{1'b0}};
        vend_d    = 1'b0;
        timeout_d = 1'b0;
        reject_d  = 1'b0;
        wr_en_s   = 1'b0;
        dec_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                status_d = ST_IDLE;
                if (valid) begin
                    // A supplier write has priority; any buttons value is ignored.
                    wr_en_s = idx_valid(item);
                end else if (!srst && btn_ok_s) begin
                    sel_d     = buttons;
                    balance_d = {AMT_W{1'b0}};
                    state_d   = S_CHECK;
                    status_d  = (btn_stock_s != {CNT_W{1'b0}}) ? ST_AVAIL : ST_OOS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (srst) begin
                    state_d  = S_IDLE;
                    status_d = ST_IDLE;
                end else if (sel_stock_s != {CNT_W{1'b0}}) begin
                    state_d  = S_COLLECT;
                    status_d = ST_BUSY;
                    timer_d  = {TMR_W{1'b0}};
                    insuff_d = 1'b0;
                end else begin
                    // Out of stock: return any carried credit to the user.
                    state_d   = S_IDLE;
                    status_d  = ST_IDLE;
                    balance_d = amount_q;
                    amount_d  = {AMT_W{1'b0}};
                end
            end
            S_COLLECT: begin
                status_d = ST_BUSY;
                if (srst) begin
                    // A user cancel wins over coin, select and timeout.
                    balance_d = amount_q;
                    amount_d  = {AMT_W{1'b0}};
                    insuff_d  = 1'b0;
                    state_d   = S_REFUND;
                end else begin
                    reject_d = (coins != 2'd0) && !coin_ok_s;
                    amount_d = credit_s;
                    if (coin_ok_s) begin
                        timer_d  = {TMR_W{1'b0}};
                        insuff_d = 1'b0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                    if (select && (credit_s >= price_s)) begin
                        vend_d    = 1'b1;
                        product_d = sel_q;
                        dec_en_s  = 1'b1;
                        insuff_d  = 1'b0;
                        state_d   = S_DISPENSE;
`ifdef VM2002_CREDIT_CARRY_EN
                        amount_d  = credit_s - price_s;
                        balance_d = {AMT_W{1'b0}};
`else
                        amount_d  = {AMT_W{1'b0}};
                        balance_d = credit_s - price_s;
`endif
                    end else if (!coin_ok_s && (timer_q == TMR_LAST)) begin
                        timeout_d = 1'b1;
                        balance_d = amount_q;
                        amount_d  = {AMT_W{1'b0}};
                        insuff_d  = 1'b0;
                        state_d   = S_REFUND;
                    end else if (select) begin
                        insuff_d = 1'b1;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_DISPENSE: begin
                status_d = ST_IDLE;
                state_d  = S_IDLE;
            end
            S_REFUND: begin
                status_d = ST_IDLE;
                state_d  = S_IDLE;
            end
            default: begin
                status_d = ST_IDLE;
                state_d  = S_IDLE;
            end
        endcase
        collect_d = (state_d == S_COLLECT);
    end

    // State and output registers. Reset is asynchronous and clears everything.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state_q   <= S_IDLE;
            sel_q     <= {IDX_W{1'b0}};
            amount_q  <= {AMT_W{1'b0}};
            balance_q <= {AMT_W{1'b0}};
            timer_q   <= {TMR_W{1'b0}};
            status_q  <= ST_IDLE;
            product_q <= {IDX_W{1'b0}};
            collect_q <= 1'b0;
            insuff_q  <= 1'b0;
            timeout_q <= 1'b0;
            vend_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            amount_q  <= amount_d;
            balance_q <= balance_d;
            timer_q   <= timer_d;
            status_q  <= status_d;
            product_q <= product_d;
            collect_q <= collect_d;
            insuff_q  <= insuff_d;
            timeout_q <= timeout_d;
            vend_q    <= vend_d;
            reject_q  <= reject_d;
        end
    end

    // Stock/cost table. A supplier write loads an entry; a dispense decrements the selected stock.
    always_ff @(posedge clk or negedge hrst_n) begin
        if (!hrst_n) begin
            for (int i = 0; i <= NUM_ITEMS; i++) begin
                count_q[i] <= {CNT_W{1'b0}};
                cost_q[i]  <= {AMT_W{1'b0}};
            end
        end else begin
            for (int i = 0; i <= NUM_ITEMS; i++) begin
                if (wr_en_s && (item == IDX_W'(i))) begin
                    count_q[i] <= count;
                    cost_q[i]  <= cost;
                end else if (dec_en_s && (sel_q == IDX_W'(i))) begin
                    count_q[i] <= count_q[i] - CNT_W'(1);
                end else begin
                    count_q[i] <= count_q[i];
                end
            end
        end
    end

    assign status              = status_q;
    assign insert_coins        = collect_q;
    assign start_timer         = collect_q;
    assign timeout             = timeout_q;
    assign insufficient_amount = insuff_q;
    assign amount              = amount_q;
    assign balance             = balance_q;
    assign product             = product_q;
    assign vend                = vend_q;
    assign coin_reject         = reject_q;

endmodule

// File: tb/tb_vm2002_multi.sv
// Directed testbench for vm2002_multi with the default parameters (7 items, 8-bit amount, timeout 64).
// The credit-carry scenario runs only when VM2002_CREDIT_CARRY_EN is defined.
module tb_vm2002_multi;

    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       hrst_n;
    logic       srst;
    logic       valid;
    logic [2:0] item;
    logic [3:0] count;
    logic [7:0] cost;
    logic [2:0] buttons;
    logic [1:0] coins;
    logic       select;
    logic [1:0] status;
    logic       insert_coins;
    logic       start_timer;
    logic       timeout;
    logic       insufficient_amount;
    logic [7:0] amount;
    logic [7:0] balance;
    logic [2:0] product;
    logic       vend;
    logic       coin_reject;

    int n_cmp  = 0;
    int n_fail = 0;

    vm2002_multi dut (
        .clk                 (clk),
        .hrst_n              (hrst_n),
        .srst                (srst),
        .valid               (valid),
        .item                (item),
        .count               (count),
        .cost                (cost),
        .buttons             (buttons),
        .coins               (coins),
        .select              (select),
        .status              (status),
        .insert_coins        (insert_coins),
        .start_timer         (start_timer),
        .timeout             (timeout),
        .insufficient_amount (insufficient_amount),
        .amount              (amount),
        .balance             (balance),
        .product             (product),
        .vend                (vend),
        .coin_reject         (coin_reject)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are applied before the edge and outputs are sampled 1 ns after it.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] i, input logic [3:0] c, input logic [7:0] k);
        valid = 1'b1; item = i; count = c; cost = k;
        step();
        valid = 1'b0; item = 3'd0; count = 4'd0; cost = 8'd0;
    endtask

    task automatic test_reset;
        hrst_n = 1'b0; srst = 1'b0; valid = 1'b0; item = 3'd0; count = 4'd0;
        cost = 8'd0; buttons = 3'd0; coins = 2'd0; select = 1'b0;
        #3;
        n_cmp++;
        if ({status, insert_coins, start_timer, timeout, insufficient_amount, amount, balance, product, vend, coin_reject} !== 27'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {status, insert_coins, start_timer, timeout, insufficient_amount, amount, balance, product, vend, coin_reject});
        end
        @(negedge clk);
        hrst_n = 1'b1;
        step(); step();
        n_cmp++;
        if ({status, insert_coins, vend} !== 4'd0) begin
            n_fail++; $display("FAIL reset_idle: got %h want 0", {status, insert_coins, vend});
        end
    endtask

    task automatic test_load_buy;
        load(3'd2, 4'd3, 8'd50);
        buttons = 3'd2; step(); buttons = 3'd0;
        n_cmp++;
        if ({status, insert_coins} !== {2'd1, 1'b0}) begin
            n_fail++; $display("FAIL buy_check: status/insert got %0d/%0d want 1/0", status, insert_coins);
        end
        step();
        n_cmp++;
        if ({status, insert_coins, start_timer} !== {2'd3, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL buy_collect: status/insert/timer got %0d/%0d/%0d want 3/1/1", status, insert_coins, start_timer);
        end
        coins = 2'd3; step();
        n_cmp++;
        if (amount !== 8'd25) begin
            n_fail++; $display("FAIL buy_amount25: got %0d want 25", amount);
        end
        step(); coins = 2'd0; select = 1'b1; step(); select = 1'b0;
        n_cmp++;
        if ({vend, product, balance, amount, insert_coins} !== {1'b1, 3'd2, 8'd0, 8'd0, 1'b0}) begin
            n_fail++; $display("FAIL buy_vend: vend/product/balance/amount/insert got %0d/%0d/%0d/%0d/%0d want 1/2/0/0/0", vend, product, balance, amount, insert_coins);
        end
        step();
        n_cmp++;
        if ({vend, product, status} !== {1'b0, 3'd0, 2'd0}) begin
            n_fail++; $display("FAIL buy_after: vend/product/status got %0d/%0d/%0d want 0/0/0", vend, product, status);
        end
        n_cmp++;
        if (dut.count_q[2] !== 4'd2) begin
            n_fail++; $display("FAIL buy_stock: got %0d want 2", dut.count_q[2]);
        end
    endtask

    task automatic test_out_of_stock;
        load(3'd5, 4'd0, 8'd20);
        buttons = 3'd5; step(); buttons = 3'd0;
        n_cmp++;
        if ({status, insert_coins} !== {2'd2, 1'b0}) begin
            n_fail++; $display("FAIL oos_status: status/insert got %0d/%0d want 2/0", status, insert_coins);
        end
        step();
        n_cmp++;
        if ({status, insert_coins} !== {2'd0, 1'b0}) begin
            n_fail++; $display("FAIL oos_back_idle: status/insert got %0d/%0d want 0/0", status, insert_coins);
        end
        step();
        n_cmp++;
        if ({status, insert_coins} !== {2'd0, 1'b0}) begin
            n_fail++; $display("FAIL oos_stays_idle: status/insert got %0d/%0d want 0/0", status, insert_coins);
        end
    endtask

    task automatic test_srst_check;
        buttons = 3'd2; step(); buttons = 3'd0;
        n_cmp++;
        if (status !== 2'd1) begin
            n_fail++; $display("FAIL srst_check_avail: got %0d want 1", status);
        end
        srst = 1'b1; step(); srst = 1'b0;
        n_cmp++;
        if ({status, insert_coins} !== {2'd0, 1'b0}) begin
            n_fail++; $display("FAIL srst_check_cancel: status/insert got %0d/%0d want 0/0", status, insert_coins);
        end
        step();
        n_cmp++;
        if ({insert_coins, dut.count_q[2]} !== {1'b0, 4'd2}) begin
            n_fail++; $display("FAIL srst_check_idle: insert/stock got %0d/%0d want 0/2", insert_coins, dut.count_q[2]);
        end
    endtask

    task automatic test_insufficient_timeout;
        logic seen_to;
        load(3'd1, 4'd1, 8'd100);
        buttons = 3'd1; step(); buttons = 3'd0; step();
        coins = 2'd3; step(); coins = 2'd0;
        select = 1'b1; step(); select = 1'b0;
        n_cmp++;
        if ({insufficient_amount, vend, amount} !== {1'b1, 1'b0, 8'd25}) begin
            n_fail++; $display("FAIL insuff_set: insuff/vend/amount got %0d/%0d/%0d want 1/0/25", insufficient_amount, vend, amount);
        end
        coins = 2'd1; step(); coins = 2'd0;
        n_cmp++;
        if ({insufficient_amount, amount} !== {1'b0, 8'd30}) begin
            n_fail++; $display("FAIL insuff_clear_coin: insuff/amount got %0d/%0d want 0/30", insufficient_amount, amount);
        end
        select = 1'b1; step(); select = 1'b0;
        seen_to = 1'b0;
        for (int k = 0; k < TO - 2; k++) begin
            step();
            seen_to = seen_to | timeout;
        end
        n_cmp++;
        if ({seen_to, insufficient_amount, insert_coins} !== {1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL timeout_early: seen/insuff/insert got %0d/%0d/%0d want 0/1/1", seen_to, insufficient_amount, insert_coins);
        end
        step();
        n_cmp++;
        if ({timeout, balance, amount, insufficient_amount, insert_coins} !== {1'b1, 8'd30, 8'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL timeout_refund: to/balance/amount/insuff/insert got %0d/%0d/%0d/%0d/%0d want 1/30/0/0/0", timeout, balance, amount, insufficient_amount, insert_coins);
        end
        step();
        n_cmp++;
        if ({timeout, status, balance} !== {1'b0, 2'd0, 8'd30}) begin
            n_fail++; $display("FAIL timeout_after: to/status/balance got %0d/%0d/%0d want 0/0/30", timeout, status, balance);
        end
    endtask

    task automatic test_coin_reject_cancel;
        load(3'd4, 4'd2, 8'd255);
        buttons = 3'd4; step(); buttons = 3'd0; step();
        coins = 2'd3;
        for (int k = 0; k < 10; k++) step();
        n_cmp++;
        if ({amount, coin_reject} !== {8'd250, 1'b0}) begin
            n_fail++; $display("FAIL reject_fill: amount/reject got %0d/%0d want 250/0", amount, coin_reject);
        end
        coins = 2'd2; step();
        n_cmp++;
        if ({coin_reject, amount} !== {1'b1, 8'd250}) begin
            n_fail++; $display("FAIL reject_10: reject/amount got %0d/%0d want 1/250", coin_reject, amount);
        end
        coins = 2'd1; valid = 1'b1; item = 3'd3; count = 4'd9; cost = 8'd40; step();
        valid = 1'b0;
        n_cmp++;
        if ({coin_reject, amount} !== {1'b0, 8'd255}) begin
            n_fail++; $display("FAIL accept_to_max: reject/amount got %0d/%0d want 0/255", coin_reject, amount);
        end
        step();
        n_cmp++;
        if ({coin_reject, amount} !== {1'b1, 8'd255}) begin
            n_fail++; $display("FAIL reject_at_max: reject/amount got %0d/%0d want 1/255", coin_reject, amount);
        end
        coins = 2'd3; srst = 1'b1; step(); coins = 2'd0; srst = 1'b0;
        n_cmp++;
        if ({balance, amount, insert_coins, coin_reject, timeout} !== {8'd255, 8'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL srst_refund: balance/amount/insert/reject/to got %0d/%0d/%0d/%0d/%0d want 255/0/0/0/0", balance, amount, insert_coins, coin_reject, timeout);
        end
        step();
        n_cmp++;
        if ({status, dut.count_q[3], dut.count_q[4]} !== {2'd0, 4'd0, 4'd2}) begin
            n_fail++; $display("FAIL busy_write_ignored: status/stock3/stock4 got %0d/%0d/%0d want 0/0/2", status, dut.count_q[3], dut.count_q[4]);
        end
    endtask

    task automatic test_reset_mid_collect;
        buttons = 3'd2; step(); buttons = 3'd0; step();
        coins = 2'd3; step(); coins = 2'd2; step(); coins = 2'd0;
        n_cmp++;
        if (amount !== 8'd35) begin
            n_fail++; $display("FAIL midreset_amount: got %0d want 35", amount);
        end
        #2 hrst_n = 1'b0;
        #1;
        n_cmp++;
        if ({status, insert_coins, start_timer, timeout, insufficient_amount, amount, balance, product, vend, coin_reject} !== 27'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %h want 0", {status, insert_coins, start_timer, timeout, insufficient_amount, amount, balance, product, vend, coin_reject});
        end
        n_cmp++;
        if ({dut.state_q, dut.count_q[2], dut.cost_q[2], dut.count_q[4]} !== 23'd0) begin
            n_fail++; $display("FAIL midreset_tables: state/stock2/cost2/stock4 got %0d/%0d/%0d/%0d want 0/0/0/0", dut.state_q, dut.count_q[2], dut.cost_q[2], dut.count_q[4]);
        end
        @(negedge clk);
        hrst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back;
        load(3'd2, 4'd5, 8'd50);
        buttons = 3'd2; step(); buttons = 3'd0; step();
        coins = 2'd3; step(); step();
        coins = 2'd2; select = 1'b1; step(); coins = 2'd0; select = 1'b0;
`ifdef VM2002_CREDIT_CARRY_EN
        n_cmp++;
        if ({vend, product, balance, amount} !== {1'b1, 3'd2, 8'd0, 8'd10}) begin
            n_fail++; $display("FAIL b2b_vend: vend/product/balance/amount got %0d/%0d/%0d/%0d want 1/2/0/10", vend, product, balance, amount);
        end
`else
        n_cmp++;
        if ({vend, product, balance, amount} !== {1'b1, 3'd2, 8'd10, 8'd0}) begin
            n_fail++; $display("FAIL b2b_vend: vend/product/balance/amount got %0d/%0d/%0d/%0d want 1/2/10/0", vend, product, balance, amount);
        end
`endif
        step();
        buttons = 3'd2; step(); buttons = 3'd0;
        n_cmp++;
        if ({status, balance} !== {2'd1, 8'd0}) begin
            n_fail++; $display("FAIL b2b_next_select: status/balance got %0d/%0d want 1/0", status, balance);
        end
        step();
        n_cmp++;
        if ({insert_coins, dut.count_q[2]} !== {1'b1, 4'd4}) begin
            n_fail++; $display("FAIL b2b_next_collect: insert/stock got %0d/%0d want 1/4", insert_coins, dut.count_q[2]);
        end
        srst = 1'b1; step(); srst = 1'b0; step();
    endtask

`ifdef VM2002_CREDIT_CARRY_EN
    task automatic test_credit_carry;
        @(negedge clk); hrst_n = 1'b0;
        @(negedge clk); hrst_n = 1'b1;
        step();
        load(3'd6, 4'd2, 8'd50);
        buttons = 3'd6; step(); buttons = 3'd0; step();
        coins = 2'd3; step(); step(); step(); coins = 2'd0;
        select = 1'b1; step(); select = 1'b0;
        n_cmp++;
        if ({vend, amount, balance} !== {1'b1, 8'd25, 8'd0}) begin
            n_fail++; $display("FAIL carry_vend: vend/amount/balance got %0d/%0d/%0d want 1/25/0", vend, amount, balance);
        end
        step();
        buttons = 3'd6; step(); buttons = 3'd0;
        n_cmp++;
        if ({status, amount} !== {2'd1, 8'd25}) begin
            n_fail++; $display("FAIL carry_kept: status/amount got %0d/%0d want 1/25", status, amount);
        end
        step(); srst = 1'b1; step(); srst = 1'b0;
        n_cmp++;
        if ({balance, amount} !== {8'd25, 8'd0}) begin
            n_fail++; $display("FAIL carry_refund: balance/amount got %0d/%0d want 25/0", balance, amount);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load_buy();
        test_out_of_stock();
        test_srst_check();
        test_insufficient_timeout();
        test_coin_reject_cancel();
        test_reset_mid_collect();
        test_back_to_back();
`ifdef VM2002_CREDIT_CARRY_EN
        test_credit_carry();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
